// File: rtl/fpu_conv_pkg.sv
// fpu_conv_pkg: shared constants and entry-width helpers for the conversion scheduler
package fpu_conv_pkg;
  localparam logic OP_ITOF = 1'b0;
  localparam logic OP_FTOI = 1'b1;
  localparam int FWORD = 32;
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction
  function automatic int entry_w(input int nreq, input int tagw);
    return id_w(nreq) + tagw + FWORD;
  endfunction
endpackage

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: synchronous FIFO with registered storage; head is read straight from the array
module conv_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d  = push ? nxt(wr_q) : wr_q;
    rd_d  = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    dout  = mem_q[rd_q];
    empty = (cnt_q == '0);
    count = cnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fpu_conv_sched.sv
// fpu_conv_sched: round-robin sharing of one fixed-latency int<->float converter,
// with credit-limited issue and an in-order result FIFO returned per requester.
module fpu_conv_sched import fpu_conv_pkg::*; #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*32-1:0]    req_data,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  output logic [NREQ-1:0]       req_ready,
  output logic [31:0]           conv_x,
  output logic                  conv_op,
  input  logic [31:0]           conv_y,
  output logic [NREQ-1:0]       resp_valid,
  output logic [31:0]           resp_data,
  output logic [TAGW-1:0]       resp_tag,
  input  logic [NREQ-1:0]       resp_ready
);
  localparam int IDW = id_w(NREQ);
  localparam int EW  = entry_w(NREQ, TAGW);
  localparam int CW  = $clog2(DEPTH + 1);
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, gnt_id, head_id;
  logic [CW-1:0]   credits_q, credits_d, fifo_cnt;
  logic            gnt_any, issue, push, pop, empty;
  logic            pv_q [LATENCY];
  logic            pv_d [LATENCY];
  logic [IDW-1:0]  pid_q [LATENCY];
  logic [IDW-1:0]  pid_d [LATENCY];
  logic [TAGW-1:0] ptag_q [LATENCY];
  logic [TAGW-1:0] ptag_d [LATENCY];
  logic [EW-1:0]   fifo_dout;
  // Scan downward so the index closest to rr_ptr is the last one written and wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end
  always_comb begin
    issue     = gnt_any && (credits_q != '0);
    req_ready = issue ? NREQ'(1) << gnt_id : '0;
    conv_x    = issue ? req_data[gnt_id*FWORD +: FWORD] : '0;
    conv_op   = issue ? req_op[gnt_id] : OP_ITOF;
    rr_ptr_d  = !issue ? rr_ptr_q : (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    pop       = (fifo_cnt != '0) && resp_ready[head_id];
    credits_d = credits_q - CW'(issue) + CW'(pop);
    pv_d[0]   = issue;
    pid_d[0]  = gnt_id;
    ptag_d[0] = req_tag[gnt_id*TAGW +: TAGW];
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i]   = pv_q[i-1];
      pid_d[i]  = pid_q[i-1];
      ptag_d[i] = ptag_q[i-1];
    end
    push       = pv_q[LATENCY-1];
    resp_valid = empty ? '0 : NREQ'(1) << head_id;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q  <= '0;
      credits_q <= CW'(DEPTH);
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i]   <= 1'b0;
        pid_q[i]  <= '0;
        ptag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i]   <= pv_d[i];
        pid_q[i]  <= pid_d[i];
        ptag_q[i] <= ptag_d[i];
      end
    end
  end
  conv_result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   ({pid_q[LATENCY-1], ptag_q[LATENCY-1], conv_y}),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_cnt)
  );
  assign {head_id, resp_tag, resp_data} = fifo_dout;
endmodule

// File: tb/tb_fpu_conv_sched.sv
// tb_fpu_conv_sched: directed scenarios for the shared converter scheduler,
// with a one-cycle behavioural converter standing in for the FPU datapath.
module tb_fpu_conv_sched;
  logic        clk, rstn;
  logic [1:0]  req_valid, req_op, req_ready, resp_valid, resp_ready;
  logic [63:0] req_data;
  logic [9:0]  req_tag;
  logic [31:0] conv_x, conv_y, resp_data;
  logic        conv_op;
  logic [4:0]  resp_tag;
  int vec = 0;
  int errs = 0;
  logic [31:0] exp_b2b [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

  fpu_conv_sched dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .conv_x(conv_x), .conv_op(conv_op), .conv_y(conv_y),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag), .resp_ready(resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] itof(input logic [31:0] x);
    logic [31:0] m, f;
    int p;
    if (x == 32'd0) return 32'd0;
    m = x[31] ? -x : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    f = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
    return {x[31], 8'(127 + p), f[22:0]};
  endfunction

  function automatic logic [31:0] ftoi(input logic [31:0] f);
    logic [31:0] v;
    int e;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 32'd0;
    v = {8'd0, 1'b1, f[22:0]};
    v = (e >= 23) ? (v << (e - 23)) : (v >> (23 - e));
    return f[31] ? -v : v;
  endfunction

  always @(posedge clk) conv_y <= conv_op ? ftoi(conv_x) : itof(conv_x);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; req_op = '0; req_data = '0; req_tag = '0; resp_ready = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0; req_op = '0; req_data = '0; req_tag = '0; resp_ready = '0;
    @(negedge clk);
    vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL reset_resp_valid: got %b exp 00", resp_valid); end
    vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    vec++; if (conv_x !== 32'd0 || conv_op !== 1'b0) begin errs++; $display("FAIL reset_conv: got %h/%b exp 0/0", conv_x, conv_op); end
    vec++; if (dut.credits_q !== 3'd4) begin errs++; $display("FAIL reset_credits: got %0d exp 4", dut.credits_q); end
    vec++; if (dut.rr_ptr_q !== 1'b0) begin errs++; $display("FAIL reset_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_single_itof();
    do_reset();
    req_valid = 2'b01; req_data[31:0] = 32'h1; req_tag[4:0] = 5'd3; req_op = 2'b00;
    @(negedge clk);
    vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL single_grant: got %b exp 01", req_ready); end
    vec++; if (conv_x !== 32'h1 || conv_op !== 1'b0) begin errs++; $display("FAIL single_conv: got %h/%b exp 1/0", conv_x, conv_op); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL single_early: got %b exp 00", resp_valid); end
    tick();
    @(negedge clk);
    vec++; if (resp_valid !== 2'b01) begin errs++; $display("FAIL single_resp_valid: got %b exp 01", resp_valid); end
    vec++; if (resp_data !== 32'h3F800000) begin errs++; $display("FAIL single_data: got %h exp 3f800000", resp_data); end
    vec++; if (resp_tag !== 5'd3) begin errs++; $display("FAIL single_tag: got %0d exp 3", resp_tag); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    @(negedge clk);
    vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL single_popped: got %b exp 00", resp_valid); end
    vec++; if (dut.credits_q !== 3'd4) begin errs++; $display("FAIL single_credits: got %0d exp 4", dut.credits_q); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0]  exp_t [4] = '{5'd10, 5'd20, 5'd10, 5'd20};
    logic [31:0] exp_d [4] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40400000};
    do_reset();
    req_data = {32'd3, 32'd2}; req_tag = {5'd20, 5'd10}; resp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (c < 4) begin
        vec++; if (req_ready !== exp_g[c]) begin errs++; $display("FAIL cont_grant%0d: got %b exp %b", c, req_ready, exp_g[c]); end
      end
      if (c >= 2) begin
        vec++; if (resp_valid !== exp_g[c-2] || resp_tag !== exp_t[c-2] || resp_data !== exp_d[c-2]) begin
          errs++; $display("FAIL cont_result%0d: got %b/%0d/%h exp %b/%0d/%h", c - 2, resp_valid, resp_tag, resp_data, exp_g[c-2], exp_t[c-2], exp_d[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_credit_stall();
    int issues;
    do_reset();
    req_valid = 2'b01; req_data[31:0] = 32'd5; req_tag[4:0] = 5'd7;
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready[0]) issues++;
      tick();
    end
    vec++; if (issues != 4) begin errs++; $display("FAIL stall_issues: got %0d exp 4", issues); end
    resp_ready = 2'b01;
    @(negedge clk);
    vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL stall_ready: got %b exp 00", req_ready); end
    vec++; if (resp_valid !== 2'b01 || resp_data !== 32'h40A00000 || resp_tag !== 5'd7) begin
      errs++; $display("FAIL stall_head: got %b/%h/%0d exp 01/40a00000/7", resp_valid, resp_data, resp_tag);
    end
    tick();
    resp_ready = 2'b00;
    issues = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (req_ready[0]) issues++;
      tick();
    end
    vec++; if (issues != 1) begin errs++; $display("FAIL stall_reissue: got %0d exp 1", issues); end
    vec++; if (dut.credits_q !== 3'd0) begin errs++; $display("FAIL stall_credits: got %0d exp 0", dut.credits_q); end
    req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    resp_ready = 2'b11;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 10) ? 2'b11 : 2'b00;
      req_data = {32'(c + 1), 32'(c + 1)};
      req_tag = {5'(c), 5'(c)};
      @(negedge clk);
      if (c < 10) begin
        vec++; if (req_ready !== ((c % 2) ? 2'b10 : 2'b01)) begin errs++; bad++; $display("FAIL b2b_grant%0d: got %b exp %b", c, req_ready, (c % 2) ? 2'b10 : 2'b01); end
      end
      if (c >= 2) begin
        vec++; if (resp_valid !== (((c - 2) % 2) ? 2'b10 : 2'b01) || resp_tag !== 5'(c - 2) || resp_data !== exp_b2b[c-2]) begin
          errs++; bad++; $display("FAIL b2b_result%0d: got %b/%0d/%h exp %0d/%h", c - 2, resp_valid, resp_tag, resp_data, c - 2, exp_b2b[c-2]);
        end
      end
      if (c >= 2 && c <= 10) begin
        vec++; if (dut.credits_q !== 3'd2) begin errs++; $display("FAIL b2b_credits%0d: got %0d exp 2", c, dut.credits_q); end
      end
      tick();
    end
    @(negedge clk);
    vec++; if (resp_valid !== 2'b00 || dut.credits_q !== 3'd4) begin
      errs++; $display("FAIL b2b_drain: got %b/%0d exp 00/4", resp_valid, dut.credits_q);
    end
    tick();
  endtask

  task automatic test_zero_ftoi();
    do_reset();
    resp_ready = 2'b00;
    req_valid = 2'b10; req_op = 2'b10; req_data[63:32] = 32'h40400000; req_tag[9:5] = 5'd9;
    @(negedge clk);
    vec++; if (req_ready !== 2'b10 || conv_op !== 1'b1 || conv_x !== 32'h40400000) begin
      errs++; $display("FAIL ftoi_issue: got %b/%b/%h exp 10/1/40400000", req_ready, conv_op, conv_x);
    end
    tick();
    req_valid = 2'b01; req_op = 2'b00; req_data[31:0] = 32'h0; req_tag[4:0] = 5'd4;
    @(negedge clk);
    vec++; if (req_ready !== 2'b01 || conv_op !== 1'b0) begin errs++; $display("FAIL zero_issue: got %b/%b exp 01/0", req_ready, conv_op); end
    tick();
    req_valid = 2'b00;
    resp_ready = 2'b11;
    @(negedge clk);
    vec++; if (resp_valid !== 2'b10 || resp_data !== 32'd3 || resp_tag !== 5'd9) begin
      errs++; $display("FAIL ftoi_result: got %b/%h/%0d exp 10/00000003/9", resp_valid, resp_data, resp_tag);
    end
    tick();
    @(negedge clk);
    vec++; if (resp_valid !== 2'b01 || resp_data !== 32'h0 || resp_tag !== 5'd4) begin
      errs++; $display("FAIL zero_result: got %b/%h/%0d exp 01/00000000/4", resp_valid, resp_data, resp_tag);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int stale;
    do_reset();
    resp_ready = 2'b00;
    req_valid = 2'b01; req_data[31:0] = 32'd1; req_tag[4:0] = 5'd2; req_op = 2'b00;
    tick();
    tick();
    tick();
    vec++; if (resp_valid !== 2'b01 || dut.credits_q !== 3'd1) begin
      errs++; $display("FAIL midop_pre: got %b/%0d exp 01/1", resp_valid, dut.credits_q);
    end
    rstn = 1'b0;
    req_valid = 2'b00;
    #1;
    vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL midop_resp_valid: got %b exp 00", resp_valid); end
    vec++; if (dut.credits_q !== 3'd4 || dut.rr_ptr_q !== 1'b0) begin
      errs++; $display("FAIL midop_state: got %0d/%0d exp 4/0", dut.credits_q, dut.rr_ptr_q);
    end
    tick();
    rstn = 1'b1;
    resp_ready = 2'b11;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) stale++;
      tick();
    end
    vec++; if (stale != 0) begin errs++; $display("FAIL midop_stale: got %0d exp 0", stale); end
    req_valid = 2'b10; req_data[63:32] = 32'd1; req_tag[9:5] = 5'd1;
    @(negedge clk);
    vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL midop_reissue: got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    vec++; if (resp_valid !== 2'b10 || resp_data !== 32'h3F800000 || resp_tag !== 5'd1) begin
      errs++; $display("FAIL midop_fresh: got %b/%h/%0d exp 10/3f800000/1", resp_valid, resp_data, resp_tag);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_itof();
    test_contention();
    test_credit_stall();
    test_back_to_back();
    test_zero_ftoi();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
